// File: rtl/access_ctrl.sv
// rtl/access_ctrl.sv - per-user resource access control with lockout after repeated denials
module access_ctrl #(
    parameter int UID_W       = 4,
    parameter int RID_W       = 4,
    parameter int NUM_RES     = 10,
    parameter int MULT        = 3,
    parameter int DENY_LIMIT  = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [UID_W-1:0]   req_uid,
    input  logic               perm_we,
    input  logic [UID_W-1:0]   perm_uid,
    input  logic [NUM_RES-1:0] perm_mask,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [RID_W-1:0]   resp_rid,
    output logic               resp_grant,
    output logic               resp_locked,
    output logic [7:0]         deny_total
);
    localparam int NUM_USERS = 1 << UID_W;
    localparam int CNT_W     = $clog2(DENY_LIMIT + 1);
    localparam int LOCK_W    = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t             state_q, state_d;
    logic [UID_W-1:0]   uid_q, uid_d;
    logic [RID_W-1:0]   rid_q, rid_d;
    logic               grant_q, grant_d;
    logic               locked_q, locked_d;
    logic [7:0]         deny_total_q, deny_total_d;
    logic [NUM_RES-1:0] perm_q [NUM_USERS];
    logic [NUM_RES-1:0] perm_d [NUM_USERS];
    logic [CNT_W-1:0]   cnt_q  [NUM_USERS];
    logic [CNT_W-1:0]   cnt_d  [NUM_USERS];
    logic [LOCK_W-1:0]  lock_q [NUM_USERS];
    logic [LOCK_W-1:0]  lock_d [NUM_USERS];

    // Mapping product kept at 32 bits so uid*MULT never wraps before the modulus.
    logic [31:0]        prod;
    logic [RID_W-1:0]   eval_rid;
    logic               eval_locked;
    logic               eval_grant;

    assign prod        = 32'(uid_q) * 32'(MULT);
    assign eval_rid    = RID_W'(prod % 32'(NUM_RES));
    assign eval_locked = (lock_q[uid_q] != '0);
    assign eval_grant  = !eval_locked && perm_q[uid_q][eval_rid];

    always_comb begin
        state_d      = state_q;
        uid_d        = uid_q;
        rid_d        = rid_q;
        grant_d      = grant_q;
        locked_d     = locked_q;
        deny_total_d = deny_total_q;
        perm_d       = perm_q;
        cnt_d        = cnt_q;
        for (int u = 0; u < NUM_USERS; u++) begin
            lock_d[u] = (lock_q[u] != '0) ? lock_q[u] - LOCK_W'(1) : '0;
        end
        // Table write lands on the clock edge, so EVAL still reads the old row.
        if (perm_we) begin
            perm_d[perm_uid] = perm_mask;
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    uid_d   = req_uid;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                rid_d    = eval_rid;
                grant_d  = eval_grant;
                locked_d = eval_locked;
                state_d  = RESP;
                if (eval_grant) begin
                    cnt_d[uid_q] = '0;
                end else begin
                    if (deny_total_q != 8'hFF) begin
                        deny_total_d = deny_total_q + 8'd1;
                    end
                    if (!eval_locked) begin
                        if (cnt_q[uid_q] == CNT_W'(DENY_LIMIT - 1)) begin
                            cnt_d[uid_q]  = '0;
                            lock_d[uid_q] = LOCK_W'(LOCK_CYCLES);
                        end else begin
                            cnt_d[uid_q] = cnt_q[uid_q] + CNT_W'(1);
                        end
                    end
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            uid_q        <= '0;
            rid_q        <= '0;
            grant_q      <= 1'b0;
            locked_q     <= 1'b0;
            deny_total_q <= '0;
            for (int u = 0; u < NUM_USERS; u++) begin
                perm_q[u] <= '1;
                cnt_q[u]  <= '0;
                lock_q[u] <= '0;
            end
        end else begin
            state_q      <= state_d;
            uid_q        <= uid_d;
            rid_q        <= rid_d;
            grant_q      <= grant_d;
            locked_q     <= locked_d;
            deny_total_q <= deny_total_d;
            perm_q       <= perm_d;
            cnt_q        <= cnt_d;
            lock_q       <= lock_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign resp_rid    = rid_q;
    assign resp_grant  = grant_q;
    assign resp_locked = locked_q;
    assign deny_total  = deny_total_q;
endmodule

// File: doc/access_ctrl.md
ACCESS_CTRL -- requirements
Module: access_ctrl

Interface
REQ-001 Parameter: UID_W, 4, user-id width.
REQ-002 Parameter: RID_W, 4, resource-id width; NUM_RES <= 2**RID_W.
REQ-003 Parameter: NUM_RES, 10, resource count and mapping modulus.
REQ-004 Parameter: MULT, 3, mapping multiplier.
REQ-005 Parameter: DENY_LIMIT, 3, consecutive denials that trigger lockout.
REQ-006 Parameter: LOCK_CYCLES, 16, lockout duration in clk cycles.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 req_valid  in  1  access request present.
REQ-010 req_ready  out  1  block can accept a request.
REQ-011 req_uid  in  UID_W  requesting user.
REQ-012 perm_we  in  1  permission-table write strobe.
REQ-013 perm_uid  in  UID_W  user whose permission row is written.
REQ-014 perm_mask  in  NUM_RES  new permission row; bit r = user may access resource r.
REQ-015 resp_valid  out  1  response present.
REQ-016 resp_ready  in  1  consumer accepts response.
REQ-017 resp_rid  out  RID_W  mapped resource id.
REQ-018 resp_grant  out  1  access granted.
REQ-019 resp_locked  out  1  denied because user is locked out.
REQ-020 deny_total  out  8  saturating count of all denials.

Function
REQ-021 FSM states IDLE, EVAL, RESP; IDLE->EVAL on req_valid&&req_ready; EVAL->RESP unconditionally; RESP->IDLE on resp_valid&&resp_ready.
REQ-022 req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-023 req_uid SHALL be captured on the accepting edge; resp_valid rises exactly 2 edges after acceptance.
REQ-024 resp_rid SHALL equal (uid*MULT) mod NUM_RES, product computed at full width without truncation, on grant and deny alike.
REQ-025 resp_grant = 1 iff user not locked and perm[uid][rid] = 1; resp_locked = 1 iff user lock timer nonzero at EVAL.
REQ-026 resp_rid, resp_grant, resp_locked SHALL hold stable throughout RESP regardless of resp_ready stalls.
REQ-027 Per-user consecutive-deny counter: cleared on grant; incremented on non-locked deny; on reaching DENY_LIMIT it clears and that user's lock timer loads LOCK_CYCLES.
REQ-028 Lock timers decrement by 1 every cycle while nonzero, in every state; locked denials do not touch the deny counter.
REQ-029 deny_total increments by 1 in EVAL on any deny (locked or not), saturating at 255.
REQ-030 perm_we writes perm[perm_uid] <= perm_mask in any state; a write in the EVAL cycle to the same uid SHALL NOT affect that evaluation (old value used).
REQ-031 Other users' counters and timers are unaffected by a given user's request.

Reset
REQ-032 On rst: state IDLE, req_ready=1 after release, resp_valid=0, resp_rid=0, resp_grant=0, resp_locked=0, deny_total=0.
REQ-033 On rst: all permission rows all-ones, all deny counters and lock timers 0.
REQ-034 rst asserted mid-transaction (EVAL or RESP) SHALL abort it; no response is issued.

Verification
REQ-035 After reset, uid=7 accepted -> 2 edges later resp_valid=1, resp_rid=1, resp_grant=1, resp_locked=0.
REQ-036 uid=15 -> resp_rid=5, resp_grant=1; uid=0 -> resp_rid=0, grant=1.
REQ-037 perm_we uid=4 mask=10'h3FB; three uid=4 requests -> deny, rid=2, locked=0; fourth -> locked=1; deny_total=4.
REQ-038 After lockout, restore mask 10'h3FF, wait 16 cycles, uid=4 -> grant=1, locked=0.
REQ-039 resp_ready held 0 for 5 cycles in RESP -> resp fields stable, req_ready=0; new req_valid ignored.
REQ-040 rst pulsed in EVAL -> all outputs at reset values, perm rows all-ones; 300 denials -> deny_total=255.
